// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronizes reset release into clk_i, stretches it, then releases the
//   per-channel active-low resets one at a time in ascending index order.
//   While the sequence is DONE, software can re-assert any channel. That
//   channel and every channel above it are pulled back into reset, and the
//   sequence is replayed starting from the lowest requested channel.
//
// Ports
//   clk_i          single clock, all logic lives here
//   rst_i          asynchronous active-high reset
//   sw_rst_req_i   [NUM_CH] per-channel software reset request (level)
//   rst_n_ch_o     [NUM_CH] per-channel active-low reset, registered
//   all_released_o high in DONE only (every channel out of reset), registered
//   state_o        [2] FSM state: 0 HOLD, 1 STRETCH, 2 RELEASE, 3 DONE
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_CYC = 16,
    parameter int STAGGER_CYC = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] sw_rst_req_i,
    output logic [NUM_CH-1:0] rst_n_ch_o,
    output logic              all_released_o,
    output logic [1:0]        state_o
);

    localparam int               IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_done;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [NUM_CH-1:0]      pending;

    logic [NUM_CH-1:0]      req_all;
    logic [NUM_CH-1:0]      keep_mask;
    logic [NUM_CH-1:0]      rel_bit;
    logic [IDX_W-1:0]       low_idx;
    logic                   step_due;

    assign state_o = state;

    // Release synchronizer. It is cleared asynchronously and fills with ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_done = sync[SYNC_STAGES-1];

    always_comb begin
        // A request latched earlier and a request arriving now are treated
        // as one mask.
        req_all = pending | sw_rst_req_i;
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req_all[i]) low_idx = IDX_W'(i);
        keep_mask = '0;
        rel_bit   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            keep_mask[i] = (IDX_W'(i) < low_idx);
            rel_bit[i]   = (IDX_W'(i) == idx);
        end
        step_due = (state == STRETCH) ? (cnt == STRETCH_LAST) : (cnt == STAGGER_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= HOLD;
            cnt            <= '0;
            idx            <= '0;
            pending        <= '0;
            rst_n_ch_o     <= '0;
            all_released_o <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (sync_done) begin
                        state <= STRETCH;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                // STRETCH releases channel idx. RELEASE then waits STAGGER_CYC
                // cycles between each later channel. Both states share the
                // same release step.
                STRETCH, RELEASE: begin
                    if (step_due) begin
                        rst_n_ch_o <= rst_n_ch_o | rel_bit;
                        cnt        <= '0;
                        if (idx == LAST_IDX) begin
                            state          <= DONE;
                            all_released_o <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            idx   <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (|req_all) begin
                        // Channels below the lowest requested one stay out
                        // of reset, so the ordering invariant holds.
                        rst_n_ch_o     <= rst_n_ch_o & keep_mask;
                        all_released_o <= 1'b0;
                        state          <= STRETCH;
                        idx            <= low_idx;
                        cnt            <= '0;
                    end
                end
                default: state <= HOLD;
            endcase

            // Requests seen outside DONE are kept until DONE can act on them.
            if (state == DONE) pending <= '0;
            else               pending <= pending | sw_rst_req_i;
        end
    end

endmodule
